mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the CPU's single-port byte memory (32 × 8 bit: program at 0x00–0x0F, variables at 0x11–0x13). Shares the memory between the CPU port (instruction fetch and LOAD/STORE) and a debug/loader port that preloads programs and reads results. Each access is issued as a one-cycle memory strobe, and read data is routed back to the owning requester. Arbitration is round-robin by default, or fixed priority under a build option.

---
 rtl/mem_arbiter.sv | 105 ++++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (CPU / debug loader) arbiter and sequencer for a single-port byte memory.
// Round-robin by default; define MEM_ARB_FIXED_PRIO_EN for fixed debug priority.
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state;
  logic   owner;    // 0 = cpu, 1 = dbg
  logic   arb_pt;
  logic   req_c, req_d;
  logic   win;
`ifndef MEM_ARB_FIXED_PRIO_EN
  logic   last_winner;
`endif

  // mem_* hold the latched request while in ISSUE, so mem_we doubles as the access type.
  always_comb begin
    arb_pt = (state == IDLE) || (state == RESP) || (state == ISSUE && mem_we);
    req_c  = cpu_req && !(state == ISSUE && !owner);
    req_d  = dbg_req && !(state == ISSUE &&  owner);
`ifdef MEM_ARB_FIXED_PRIO_EN
    win    = req_d;
`else
    win    = (req_c && req_d) ? ~last_winner : req_d;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      cpu_gnt     <= 1'b0;
      dbg_gnt     <= 1'b0;
      cpu_rvalid  <= 1'b0;
      dbg_rvalid  <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
`ifndef MEM_ARB_FIXED_PRIO_EN
      last_winner <= 1'b1;
`endif
    end else begin
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if (arb_pt) begin
        if (req_c || req_d) begin
          state     <= ISSUE;
          owner     <= win;
          cpu_gnt   <= !win;
          dbg_gnt   <= win;
          mem_en    <= 1'b1;
          mem_we    <= win ? dbg_we    : cpu_we;
          mem_addr  <= win ? dbg_addr  : cpu_addr;
          mem_wdata <= win ? dbg_wdata : cpu_wdata;
`ifndef MEM_ARB_FIXED_PRIO_EN
          last_winner <= win;
`endif
        end else begin
          state <= IDLE;
        end
      end else begin
        // read in ISSUE: data returns next cycle to the owner only
        state      <= RESP;
        cpu_rvalid <= !owner;
        dbg_rvalid <= owner;
      end
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
`define CHK(tag, o, e) chk(tag, 64'(o), 64'(e))
module tb_mem_arbiter;
  logic       clk, reset;
  logic       cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic       dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [4:0] dbg_addr;
  logic [7:0] dbg_wdata, dbg_rdata;
  logic       mem_en, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic [7:0] mem [32];

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [34:0] all_out();
    return {cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
            mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic access(input bit p, input bit we, input logic [4:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd);
    if (p) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = d; end
    else   begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d; end
    tick();
    `CHK("acc_gnt",   p ? dbg_gnt : cpu_gnt, 1);
    `CHK("acc_ogn",   p ? cpu_gnt : dbg_gnt, 0);
    `CHK("acc_en",    mem_en, 1);
    `CHK("acc_we",    mem_we, we);
    `CHK("acc_addr",  mem_addr, a);
    if (we) `CHK("acc_wd", mem_wdata, d);
    `CHK("acc_norv",  cpu_rvalid | dbg_rvalid, 0);
    cpu_req = 0; dbg_req = 0;
    tick();
    if (!we) begin
      `CHK("acc_rv",    p ? dbg_rvalid : cpu_rvalid, 1);
      `CHK("acc_orv",   p ? cpu_rvalid : dbg_rvalid, 0);
      `CHK("acc_rdata", p ? dbg_rdata : cpu_rdata, exp_rd);
      `CHK("acc_rd_en", mem_en, 0);
      tick();
    end
    `CHK("acc_quiet", all_out(), 0);
  endtask

  initial begin
    bit f;
    int prev, grants;
    logic prev_rd;
    reset = 0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    #2 `CHK("rst_out", all_out(), 0);
    #20;
    @(negedge clk) reset = 1;
    tick();
    `CHK("idle_out", all_out(), 0);

    dbg_req = 1; dbg_we = 0; dbg_addr = 5'h11;
    tick();
    `CHK("mr_gnt", dbg_gnt, 1);
    `CHK("mr_addr", mem_addr, 5'h11);
    dbg_req = 0;
    tick();
    `CHK("mr_rv", dbg_rvalid, 1);
    #2 reset = 0;
    #1 `CHK("mr_rst_out", all_out(), 0);
    @(negedge clk) reset = 1;
    tick();
    `CHK("mr_after", all_out(), 0);

    access(1, 1, 5'h00, 8'h11, 8'h00);
    access(1, 1, 5'h11, 8'h05, 8'h00);
    access(1, 1, 5'h12, 8'h01, 8'h00);
    access(1, 1, 5'h13, 8'h07, 8'h00);
    access(1, 0, 5'h11, 8'h00, 8'h05);
    access(0, 0, 5'h00, 8'h00, 8'h11);

    reset = 0;
    #3 `CHK("tie_rst", all_out(), 0);
    @(negedge clk) reset = 1;
`ifdef MEM_ARB_FIXED_PRIO_EN
    f = 1;
`else
    f = 0;
`endif
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'h13;
    dbg_req = 1; dbg_we = 0; dbg_addr = 5'h12;
    tick();
    `CHK("tie1_cgnt", cpu_gnt, !f);
    `CHK("tie1_dgnt", dbg_gnt, f);
    `CHK("tie1_addr", mem_addr, f ? 5'h12 : 5'h13);
    if (f) dbg_req = 0; else cpu_req = 0;
    tick();
    `CHK("tie1_rv", f ? dbg_rvalid : cpu_rvalid, 1);
    `CHK("tie1_rd", f ? dbg_rdata : cpu_rdata, f ? 8'h01 : 8'h07);
    `CHK("tie1_nogn", cpu_gnt | dbg_gnt, 0);
    tick();
    `CHK("tie2_gnt", f ? cpu_gnt : dbg_gnt, 1);
    `CHK("tie2_addr", mem_addr, f ? 5'h13 : 5'h12);
    cpu_req = 0; dbg_req = 0;
    tick();
    `CHK("tie2_rv", f ? cpu_rvalid : dbg_rvalid, 1);
    `CHK("tie2_rd", f ? cpu_rdata : dbg_rdata, f ? 8'h07 : 8'h01);
    tick();

    cpu_req = 1; dbg_req = 1;
    prev = 2; grants = 0; prev_rd = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ((cpu_gnt & dbg_gnt) !== 1'b0) begin
        errors++;
        $error("FAIL ct_one_gnt observed=%0h expected=0", cpu_gnt & dbg_gnt);
      end
      checks++;
      if ((prev_rd & mem_en) !== 1'b0) begin
        errors++;
        $error("FAIL ct_no_dbl observed=%0h expected=0", prev_rd & mem_en);
      end
      prev_rd = mem_en & ~mem_we;
      if (cpu_gnt || dbg_gnt) begin
        grants++;
        if (prev != 2) begin
          checks++;
          if (dbg_gnt !== (prev == 0)) begin
            errors++;
            $error("FAIL ct_alt observed=%0h expected=%0h", dbg_gnt, prev == 0);
          end
        end
        prev = dbg_gnt ? 1 : 0;
      end
      if (cpu_rvalid) begin
        checks++;
        if (cpu_rdata !== 8'h07) begin
          errors++;
          $error("FAIL ct_crd observed=%0h expected=7", cpu_rdata);
        end
      end
      if (dbg_rvalid) begin
        checks++;
        if (dbg_rdata !== 8'h01) begin
          errors++;
          $error("FAIL ct_drd observed=%0h expected=1", dbg_rdata);
        end
      end
      if (cpu_gnt) cpu_req = 0;
      if (dbg_gnt) dbg_req = 0;
      if (cpu_rvalid) cpu_req = 1;
      if (dbg_rvalid) dbg_req = 1;
    end
    checks++;
    if (grants !== 10) begin
      errors++;
      $error("FAIL ct_grants observed=%0d expected=10", grants);
    end
    cpu_req = 0; dbg_req = 0;
    tick(); tick();

    cpu_req = 1; cpu_we = 1; cpu_addr = 5'h13; cpu_wdata = 8'h06;
    tick();
    `CHK("mk_gnt", cpu_gnt, 1);
    `CHK("mk_we", mem_we, 1);
    `CHK("mk_wd", mem_wdata, 8'h06);
    tick();
    `CHK("mk_nogn", cpu_gnt, 0);
    `CHK("mk_noen", mem_en, 0);
    cpu_req = 0;
    tick();
    `CHK("mk_quiet", all_out(), 0);
    access(1, 0, 5'h13, 8'h00, 8'h06);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
